// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - active-low multiplexed 7-segment bus readback; define SEG7_BLANK_EN to accept all-off as blank
module seg7_capture #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [6:0]                    disp_in,
  input  logic [NUM_DIGITS-1:0]         an_in,
  output logic [4*NUM_DIGITS-1:0]       hex_out,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic [NUM_DIGITS-1:0]         digit_err,
  output logic                          upd_pulse,
  output logic [$clog2(NUM_DIGITS)-1:0] upd_idx
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  state_t                  state;
  logic [7:0]              count;
  logic [6:0]              prev_disp;
  logic [NUM_DIGITS-1:0]   prev_an;

  logic                    addressable;
  logic                    same;
  logic [IW-1:0]           cap_idx;
  logic [5:0]              dec;

  // Result is {match, blank, nibble}; the segment lines are active-low, a..g from bit 6 down.
  function automatic logic [5:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode = {2'b10, 4'h0};
      7'b1001111: decode = {2'b10, 4'h1};
      7'b0010010: decode = {2'b10, 4'h2};
      7'b0000110: decode = {2'b10, 4'h3};
      7'b1001100: decode = {2'b10, 4'h4};
      7'b0100100: decode = {2'b10, 4'h5};
      7'b0100000: decode = {2'b10, 4'h6};
      7'b0001111: decode = {2'b10, 4'h7};
      7'b0000000: decode = {2'b10, 4'h8};
      7'b0000100: decode = {2'b10, 4'h9};
      7'b0001000: decode = {2'b10, 4'hA};
      7'b1100000: decode = {2'b10, 4'hB};
      7'b0110001: decode = {2'b10, 4'hC};
      7'b1000010: decode = {2'b10, 4'hD};
      7'b0110000: decode = {2'b10, 4'hE};
      7'b0111000: decode = {2'b10, 4'hF};
`ifdef SEG7_BLANK_EN
      7'b1111111: decode = {2'b01, 4'h0};
`endif
      default:    decode = 6'b000000;
    endcase
  endfunction

  // Frame qualification: exactly one active anode, comparison with the previous frame, and decode of the held frame.
  always_comb begin
    addressable = ($countones(~an_in) == 1);
    same        = (disp_in == prev_disp) && (an_in == prev_an);
    cap_idx     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!prev_an[i]) cap_idx = IW'(i);
    end
    dec = decode(prev_disp);
  end

  // Stability FSM; the capture uses the previous (stable) frame, so a change on the capture edge cannot corrupt it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= 8'd0;
      prev_disp   <= '1;
      prev_an     <= '1;
      hex_out     <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      upd_pulse   <= 1'b0;
      upd_idx     <= '0;
    end else begin
      upd_pulse <= 1'b0;
      prev_disp <= disp_in;
      prev_an   <= an_in;
      case (state)
        IDLE: begin
          if (addressable) begin
            state <= SETTLE;
            count <= 8'd1;
          end
        end
        SETTLE: begin
          if (count == STABLE_C) begin
            upd_pulse <= 1'b1;
            upd_idx   <= cap_idx;
            if (dec[5]) begin
              hex_out[4*cap_idx +: 4] <= dec[3:0];
              digit_valid[cap_idx]    <= 1'b1;
              digit_err[cap_idx]      <= 1'b0;
            end else if (dec[4]) begin
              digit_valid[cap_idx] <= 1'b0;
              digit_err[cap_idx]   <= 1'b0;
            end else begin
              digit_valid[cap_idx] <= 1'b0;
              digit_err[cap_idx]   <= 1'b1;
            end
            if (same) begin
              state <= CAPTURED;
              count <= 8'd0;
            end else if (addressable) begin
              state <= SETTLE;
              count <= 8'd1;
            end else begin
              state <= IDLE;
              count <= 8'd0;
            end
          end else if (same) begin
            count <= count + 8'd1;
          end else if (addressable) begin
            count <= 8'd1;
          end else begin
            state <= IDLE;
            count <= 8'd0;
          end
        end
        CAPTURED: begin
          if (!same) begin
            if (addressable) begin
              state <= SETTLE;
              count <= 8'd1;
            end else begin
              state <= IDLE;
              count <= 8'd0;
            end
          end
        end
        default: begin
          state <= IDLE;
          count <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - vector table and scoreboard bench for seg7_capture
module tb_seg7_capture;
  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    disp_in = 7'b1111111;
  logic [ND-1:0] an_in = '1;
  logic [4*ND-1:0] hex_out;
  logic [ND-1:0] digit_valid;
  logic [ND-1:0] digit_err;
  logic          upd_pulse;
  logic [2:0]    upd_idx;

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .disp_in(disp_in), .an_in(an_in),
    .hex_out(hex_out), .digit_valid(digit_valid), .digit_err(digit_err),
    .upd_pulse(upd_pulse), .upd_idx(upd_idx)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct { int idx; int edge_at; } sb_t;
  typedef struct {
    logic [6:0]  disp;
    logic [5:0]  an;
    int          hold;
    bit          cap;
    int          idx;
    bit          chk;
    logic [23:0] hex;
    logic [5:0]  valid;
    logic [5:0]  err;
  } vec_t;

  sb_t  sbq[$];
  vec_t vt[15];
  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;

`ifdef SEG7_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  function automatic logic [5:0] dig(input int i);
    logic [5:0] v;
    v = '1;
    v[i] = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input int edge_at);
    sb_t e;
    e.idx = idx;
    e.edge_at = edge_at;
    sbq.push_back(e);
  endtask

  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    edge_n++;
    if (upd_pulse !== 1'b0) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: actual upd_pulse=%b upd_idx=%0d at edge %0d, required no capture", upd_pulse, upd_idx, edge_n);
      end else begin
        e = sbq.pop_front();
        check("upd_idx", 32'(upd_idx), 32'(e.idx));
        if (e.edge_at >= 0) check("pulse_edge", 32'(edge_n), 32'(e.edge_at));
      end
    end
  endtask

  task automatic hold(input logic [6:0] d, input logic [5:0] a, input int n);
    disp_in = d;
    an_in = a;
    repeat (n) step();
  endtask

  task automatic check_outputs(input string tag, input logic [23:0] h, input logic [5:0] v, input logic [5:0] e);
    check({tag, "_hex"}, 32'(hex_out), 32'(h));
    check({tag, "_valid"}, 32'(digit_valid), 32'(v));
    check({tag, "_err"}, 32'(digit_err), 32'(e));
    check({tag, "_pending"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    disp_in = 7'b1111111;
    an_in = '1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int base;
    vt[0]  = '{7'b1001111, dig(0), 8, 1, 0, 1, 24'h000001, 6'b000001, 6'b000000};
    vt[1]  = '{7'b0010010, dig(1), 8, 1, 1, 1, 24'h000021, 6'b000011, 6'b000000};
    vt[2]  = '{7'b0000110, dig(2), 8, 1, 2, 1, 24'h000321, 6'b000111, 6'b000000};
    vt[3]  = '{7'b1001100, dig(3), 8, 1, 3, 1, 24'h004321, 6'b001111, 6'b000000};
    vt[4]  = '{7'b0100100, dig(4), 8, 1, 4, 1, 24'h054321, 6'b011111, 6'b000000};
    vt[5]  = '{7'b0111000, dig(5), 8, 1, 5, 1, 24'hF54321, 6'b111111, 6'b000000};
    vt[6]  = '{7'b0000000, 6'b111100, 10, 0, 0, 1, 24'hF54321, 6'b111111, 6'b000000};
    vt[7]  = '{7'b1111110, dig(2), 4, 1, 2, 0, 24'h0, 6'b0, 6'b0};
    vt[8]  = '{7'b1111111, 6'b111111, 2, 0, 0, 1, 24'hF54321, 6'b111011, 6'b000100};
    vt[9]  = '{7'b0000000, dig(0), 6, 1, 0, 1, 24'hF54328, 6'b111011, 6'b000100};
    vt[10] = '{7'b1001111, dig(4), 2, 0, 0, 0, 24'h0, 6'b0, 6'b0};
    vt[11] = '{7'b0010010, dig(4), 6, 1, 4, 1, 24'hF24328, 6'b111011, 6'b000100};
    vt[12] = '{7'b1111111, dig(3), 6, 1, 3, 1, 24'hF24328, 6'b110011, BLANK ? 6'b000100 : 6'b001100};
    vt[13] = '{7'b1000010, dig(2), 6, 1, 2, 1, 24'hF24D28, 6'b110111, BLANK ? 6'b000000 : 6'b001000};
    vt[14] = '{7'b0000000, 6'b111111, 3, 0, 0, 1, 24'hF24D28, 6'b110111, BLANK ? 6'b000000 : 6'b001000};

    // Reset state.
    do_reset();
    check_outputs("reset", 24'h0, 6'b0, 6'b0);
    check("reset_pulse", 32'(upd_pulse), 32'd0);
    check("reset_idx", 32'(upd_idx), 32'd0);

    // Latency: frame first sampled at edge base+1, capture visible after edge base+5.
    base = edge_n;
    push(0, base + 5);
    hold(7'b0000110, 6'b111110, 6);
    check_outputs("latency", 24'h000003, 6'b000001, 6'b000000);

    // Frame held one cycle short of stable, then blanked anodes: nothing captured.
    do_reset();
    hold(7'b0000110, 6'b111110, 3);
    hold(7'b0000110, 6'b111111, 6);
    check_outputs("short", 24'h0, 6'b0, 6'b0);

    // Table-driven scan, invalid anodes, bad pattern, recapture, ghosting and blank pattern.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (vt[i].cap) push(vt[i].idx, -1);
      hold(vt[i].disp, vt[i].an, vt[i].hold);
      if (vt[i].chk) check_outputs($sformatf("vec%0d", i), vt[i].hex, vt[i].valid, vt[i].err);
    end

    // Reset while a new frame is settling discards the partial count.
    do_reset();
    push(1, -1);
    hold(7'b0000000, dig(1), 6);
    check_outputs("pre_rst", 24'h000080, 6'b000010, 6'b000000);
    hold(7'b0001111, dig(2), 2);
    rst = 1'b1;
    step();
    check_outputs("mid_rst", 24'h0, 6'b0, 6'b0);
    check("mid_rst_pulse", 32'(upd_pulse), 32'd0);
    rst = 1'b0;
    base = edge_n;
    push(2, base + 5);
    repeat (6) step();
    check_outputs("post_rst", 24'h000700, 6'b000100, 6'b000000);

    // Blank pattern after a valid capture on digit 0.
    do_reset();
    push(0, -1);
    hold(7'b0001000, dig(0), 6);
    check_outputs("pre_blank", 24'h00000A, 6'b000001, 6'b000000);
    base = edge_n;
    push(0, base + 5);
    hold(7'b1111111, dig(0), 4);
    hold(7'b1111111, 6'b111111, 2);
    check_outputs("blank", 24'h00000A, 6'b000000, BLANK ? 6'b000000 : 6'b000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive-side counterpart of the team's hex-to-7-segment decoder: watches a multiplexed, active-low 7-segment bus (segments plus digit anodes) and recovers the hex nibble shown on each digit.
- Sits on the board-level display lines, or in a bench, for display readback and self-check in the frequency-meter design.
- Qualifies each digit frame with a stability counter before decoding, so ghosting during anode switching is never captured.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digits (anode lines).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (legal range 2..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- disp_in  in  7  segment lines, active-low; bit6=a, bit5=b ... bit0=g.
- an_in  in  NUM_DIGITS  digit enables, active-low; bit i selects digit i.
- hex_out  out  4*NUM_DIGITS  captured nibbles; digit i at [4i+3:4i].
- digit_valid  out  NUM_DIGITS  bit i set once digit i holds a decoded value.
- digit_err  out  NUM_DIGITS  bit i set if the last capture on digit i was an unrecognised pattern.
- upd_pulse  out  1  one-cycle strobe on every capture (valid or error).
- upd_idx  out  $clog2(NUM_DIGITS)  digit index of the capture flagged by upd_pulse.

Behaviour:
- Reset (rst=1 at a clk edge): hex_out=0, digit_valid=0, digit_err=0, upd_pulse=0, upd_idx=0, FSM=IDLE, stability counter=0. Reset mid-frame discards any partial count.
- Frame: the pair {disp_in, an_in} sampled at a clk edge. The frame is "addressable" only when exactly one bit of an_in is 0. Zero or multiple active anodes are never addressable.
- FSM states:
  - IDLE: on an addressable sample, go to SETTLE with count=1. Otherwise stay in IDLE.
  - SETTLE: if the sample equals the previous one, count+1. If it differs and is addressable, restart with count=1. If it is not addressable, go to IDLE. When count reaches STABLE_CYCLES, perform the capture and go to CAPTURED.
  - CAPTURED: hold while the sample is unchanged, so there is exactly one capture per stable window. On a change, go to SETTLE (count=1) if addressable, else IDLE.
- Capture, registered on the edge after count hits STABLE_CYCLES: upd_pulse=1 for one cycle and upd_idx=active digit.
- Decode table (disp_in -> nibble): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->b, 0110001->C, 1000010->d, 0110000->E, 0111000->F.
- Match: write the nibble to that digit, set digit_valid[i]=1 and clear digit_err[i].
- No match: leave the nibble unchanged, clear digit_valid[i] and set digit_err[i].
- Latency: if a stable addressable frame is first sampled at edge 1, outputs change after edge STABLE_CYCLES+1.
- Other digits are never touched by a capture.

Optional Feature:
- Macro: SEG7_BLANK_EN.
- Defined: pattern 1111111 (all segments off) is a legal "blank". Capturing it clears digit_valid[i] and digit_err[i], leaves the nibble unchanged, and still pulses upd_pulse.
- Undefined: 1111111 is treated as an unrecognised pattern (digit_err[i]=1).

Test Plan:
- Reset, then an_in=111110 and disp_in=0000110 held for 6 cycles -> upd_pulse exactly once after edge 5, upd_idx=0, hex_out[3:0]=3, digit_valid=000001, digit_err=0.
- Same frame held for only 3 cycles, then an_in=111111 -> no upd_pulse, all outputs stay 0.
- Scan digits 0..5 showing 1,2,3,4,5,F, each held 8 cycles -> hex_out=0xF54321, digit_valid=111111, six upd_pulse strobes with upd_idx 0..5.
- an_in=111100 (two active anodes) held 10 cycles -> no capture. Then disp_in=1111110 on digit 2 held 4 cycles -> digit_err[2]=1, digit_valid[2]=0, hex_out[11:8] unchanged.
- Digit 1 captured as 8, then rst=1 for one cycle while a new frame is settling -> all outputs return to 0 and the capture restarts from IDLE.
- SEG7_BLANK_EN defined: digit 0 = A captured, then 1111111 held 4 cycles -> digit_valid[0]=0, digit_err[0]=0, hex_out[3:0]=A, one upd_pulse.
